// File: rtl/lp_dmem_ctrl_if.sv
// Request/response channel between the FFT datapath and one memory-port controller.
interface lp_dmem_ctrl_if #(parameter int NB = 48);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [4:0]        req_addr;
    logic [32*NB-1:0]  req_wdata;
    logic              rsp_valid;
    logic [32*NB-1:0]  rsp_rdata;

    modport master (output req_valid, req_we, req_addr, req_wdata,
                    input  req_ready, rsp_valid, rsp_rdata);
    modport slave  (input  req_valid, req_we, req_addr, req_wdata,
                    output req_ready, rsp_valid, rsp_rdata);
endinterface

// File: rtl/lp_dmem_ctrl.sv
// One-port access and power-mode controller for the banked 32-word low-power data memory.
// Fixed 3-cycle read latency; light sleep is automatic, deep sleep/shutdown are commanded.
module lp_dmem_ctrl #(
    parameter int NB      = 48,
    parameter int IDLE_LS = 16,
    parameter int WAKE_LS = 2,
    parameter int WAKE_DS = 8
) (
    input  logic              clk,
    input  logic              rst,
    lp_dmem_ctrl_if.slave     dp,
    input  logic [1:0]        pwr_mode_i,
    output logic [2:0]        pwr_state_o,
    output logic              mem_csb_o,
    output logic              mem_web_o,
    output logic              mem_oeb_o,
    output logic [4:0]        mem_a_o,
    output logic [32*NB-1:0]  mem_i_o,
    input  logic [32*NB-1:0]  mem_o_i,
    output logic              mem_ls_o,
    output logic              mem_ds_o,
    output logic              mem_sd_o
);
    localparam int DW    = 32*NB;
    localparam int IW    = $clog2(IDLE_LS+1);
    localparam int WMAX  = (WAKE_DS > WAKE_LS) ? WAKE_DS : WAKE_LS;
    localparam int WW    = $clog2(WMAX+1);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_LS);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_LS-1);
    localparam logic [WW-1:0] WAKE_LS_C = WW'(WAKE_LS);
    localparam logic [WW-1:0] WAKE_DS_C = WW'(WAKE_DS);

    typedef enum logic [2:0] {
        ST_ACTIVE = 3'd0,
        ST_LSLEEP = 3'd1,
        ST_DSLEEP = 3'd2,
        ST_SDOWN  = 3'd3,
        ST_WAKE   = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   idle_q, idle_d;
    logic [WW-1:0]   wake_q, wake_d;
    logic [1:0]      mode_q;
    logic            ready_q, ready_d;
    logic            csb_q, web_q, oeb_q, rsp_valid_q;
    logic [4:0]      a_q;
    logic [DW-1:0]   i_q, rdata_q;

    logic accept, busy, mode_chg;

    assign accept   = dp.req_valid & ready_q;
    // Anything between acceptance and the response cycle counts as in flight.
    assign busy     = ~csb_q | ~oeb_q | rsp_valid_q;
    assign mode_chg = (pwr_mode_i != mode_q);

    // Access pipeline: pins -> SRAM sample -> output enable -> capture -> response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csb_q       <= 1'b1;
            web_q       <= 1'b1;
            oeb_q       <= 1'b1;
            a_q         <= '0;
            i_q         <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            csb_q       <= ~accept;
            web_q       <= ~(accept & dp.req_we);
            oeb_q       <= ~(~csb_q & web_q);
            rsp_valid_q <= ~oeb_q;
            if (accept) begin
                a_q <= dp.req_addr;
                i_q <= dp.req_wdata;
            end
            if (~oeb_q) rdata_q <= mem_o_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ACTIVE;
            idle_q  <= '0;
            wake_q  <= '0;
            mode_q  <= 2'b00;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
            wake_q  <= wake_d;
            mode_q  <= pwr_mode_i;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        wake_d  = wake_q;
        unique case (state_q)
            ST_ACTIVE: begin
                if (dp.req_valid || mode_chg)       idle_d = '0;
                else if (!busy && idle_q != IDLE_MAX) idle_d = idle_q + 1'b1;
                if (pwr_mode_i[1]) begin
                    if (!busy && !accept) state_d = pwr_mode_i[0] ? ST_SDOWN : ST_DSLEEP;
                end else if (pwr_mode_i == 2'b01 && !mode_chg && !dp.req_valid &&
                             !busy && idle_q == IDLE_LAST) begin
                    state_d = ST_LSLEEP;
                end
            end
            ST_LSLEEP: begin
                if (pwr_mode_i[1]) begin
                    state_d = pwr_mode_i[0] ? ST_SDOWN : ST_DSLEEP;
                end else if (dp.req_valid || pwr_mode_i != 2'b01) begin
                    state_d = ST_WAKE;
                    wake_d  = WAKE_LS_C;
                end
            end
            ST_DSLEEP: begin
                if (pwr_mode_i == 2'b11) begin
                    state_d = ST_SDOWN;
                end else if (!pwr_mode_i[1]) begin
                    state_d = ST_WAKE;
                    wake_d  = WAKE_DS_C;
                end
            end
            ST_SDOWN: begin
                // Shutdown never drops straight to deep sleep; it always wakes first.
                if (pwr_mode_i != 2'b11) begin
                    state_d = ST_WAKE;
                    wake_d  = WAKE_DS_C;
                end
            end
            ST_WAKE: begin
                if (wake_q <= 1) begin
                    state_d = ST_ACTIVE;
                    wake_d  = '0;
                end else begin
                    wake_d  = wake_q - 1'b1;
                end
            end
            default: state_d = ST_ACTIVE;
        endcase
        if (state_d != ST_ACTIVE) idle_d = '0;
        ready_d = (state_d == ST_ACTIVE) && !pwr_mode_i[1];
    end

    assign dp.req_ready = ready_q;
    assign dp.rsp_valid = rsp_valid_q;
    assign dp.rsp_rdata = rdata_q;
    assign pwr_state_o  = state_q;
    assign mem_csb_o    = csb_q;
    assign mem_web_o    = web_q;
    assign mem_oeb_o    = oeb_q;
    assign mem_a_o      = a_q;
    assign mem_i_o      = i_q;
    assign mem_ls_o     = (state_q == ST_LSLEEP);
    assign mem_ds_o     = (state_q == ST_DSLEEP);
    assign mem_sd_o     = (state_q == ST_SDOWN);
endmodule

// File: tb/tb_lp_dmem_ctrl.sv
// Randomized and directed bench for lp_dmem_ctrl against a memory/scoreboard model.
module tb_lp_dmem_ctrl;
    localparam int NB = 48;
    localparam int DW = 32*NB;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    pwr_mode;
    logic [2:0]    pwr_state;
    logic          mem_csb, mem_web, mem_oeb, mem_ls, mem_ds, mem_sd;
    logic [4:0]    mem_a;
    logic [DW-1:0] mem_i, mem_o;

    lp_dmem_ctrl_if #(.NB(NB)) dp();

    lp_dmem_ctrl #(.NB(NB), .IDLE_LS(16), .WAKE_LS(2), .WAKE_DS(8)) dut (
        .clk(clk), .rst(rst), .dp(dp), .pwr_mode_i(pwr_mode), .pwr_state_o(pwr_state),
        .mem_csb_o(mem_csb), .mem_web_o(mem_web), .mem_oeb_o(mem_oeb), .mem_a_o(mem_a),
        .mem_i_o(mem_i), .mem_o_i(mem_o), .mem_ls_o(mem_ls), .mem_ds_o(mem_ds), .mem_sd_o(mem_sd)
    );

    always #5 clk = ~clk;

    // SRAM macro: samples on the clock edge, drives data while OEB is low.
    logic [DW-1:0] sram [32];
    logic [DW-1:0] sram_q;
    always @(posedge clk) begin
        if (!mem_csb) begin
            if (!mem_web) sram[mem_a] <= mem_i;
            else          sram_q      <= sram[mem_a];
        end
    end
    assign mem_o = mem_oeb ? '0 : sram_q;

    typedef struct { logic [DW-1:0] data; int due; } exp_t;
    exp_t          rq[$];
    logic [DW-1:0] ref_mem [32];
    int            n_chk = 0, n_err = 0, cyc = 0, n_rsp = 0;
    bit            last_rd = 0;

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            for (int b = 0; b < NB; b++) begin
                if (act[b*32 +: 32] !== exp[b*32 +: 32]) begin
                    $display("FAIL %s bank%0d got=%h want=%h", tag, b, act[b*32 +: 32], exp[b*32 +: 32]);
                    break;
                end
            end
        end
    endtask

    task automatic drive(input bit v, input bit we, input logic [4:0] a, input logic [DW-1:0] d);
        dp.req_valid = v;
        dp.req_we    = we;
        dp.req_addr  = a;
        dp.req_wdata = d;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        for (int b = 0; b < NB; b++) d[b*32 +: 32] = $urandom;
        return d;
    endfunction

    // One clock: update the model from what was accepted, then check pins and responses.
    task automatic step();
        bit            acc, acc_we, rd_prev;
        logic [4:0]    acc_a;
        logic [DW-1:0] acc_d;
        acc     = dp.req_valid && dp.req_ready;
        acc_we  = dp.req_we;
        acc_a   = dp.req_addr;
        acc_d   = dp.req_wdata;
        rd_prev = last_rd;
        @(posedge clk); #1;
        cyc++;
        if (acc) begin
            if (acc_we) ref_mem[acc_a] = acc_d;
            else        rq.push_back('{ref_mem[acc_a], cyc + 2});
        end
        last_rd = acc && !acc_we;
        chk("csb", DW'(mem_csb), DW'(!acc));
        if (acc) begin
            chk("web", DW'(mem_web), DW'(!acc_we));
            chk("addr", DW'(mem_a), DW'(acc_a));
            if (acc_we) chk("wdata", mem_i, acc_d);
        end else begin
            chk("web_idle", DW'(mem_web), DW'(1'b1));
        end
        chk("oeb", DW'(mem_oeb), DW'(!rd_prev));
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            chk("rsp_valid", DW'(dp.rsp_valid), DW'(1'b1));
            chk("rsp_rdata", dp.rsp_rdata, rq[0].data);
            void'(rq.pop_front());
            n_rsp++;
        end else begin
            chk("rsp_quiet", DW'(dp.rsp_valid), DW'(1'b0));
        end
        chk("sleep_1hot", DW'($countones({mem_ls, mem_ds, mem_sd}) <= 1), DW'(1'b1));
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic check_reset();
        chk("rst_ready", DW'(dp.req_ready), DW'(1'b1));
        chk("rst_csb",   DW'(mem_csb), DW'(1'b1));
        chk("rst_web",   DW'(mem_web), DW'(1'b1));
        chk("rst_oeb",   DW'(mem_oeb), DW'(1'b1));
        chk("rst_a",     DW'(mem_a), '0);
        chk("rst_i",     mem_i, '0);
        chk("rst_pins",  DW'({mem_ls, mem_ds, mem_sd}), '0);
        chk("rst_rsp",   DW'(dp.rsp_valid), '0);
        chk("rst_rdata", dp.rsp_rdata, '0);
        chk("rst_state", DW'(pwr_state), '0);
    endtask

    initial begin
        logic [DW-1:0] pat;
        int            r0;
        rst      = 1'b1;
        pwr_mode = 2'b00;
        drive(0, 0, '0, '0);
        @(posedge clk); #1;
        check_reset();
        rst = 1'b0;

        // Pattern write then read at addr 5.
        pat = {NB{32'hA5A5A5A5}};
        drive(1, 1, 5'd5, pat); step();
        drive(1, 0, 5'd5, '0);  step();
        drive(0, 0, '0, '0);    steps(3);
        chk("pat_rdata", dp.rsp_rdata, pat);
        chk("pat_drained", DW'(rq.size()), '0);

        // Back-to-back fill then read-out of every word.
        for (int a = 0; a < 32; a++) begin
            drive(1, 1, 5'(a), {NB{a * 32'h01010101}});
            chk("b2b_ready_w", DW'(dp.req_ready), DW'(1'b1));
            step();
        end
        r0 = n_rsp;
        for (int a = 0; a < 32; a++) begin
            drive(1, 0, 5'(a), '0);
            chk("b2b_ready_r", DW'(dp.req_ready), DW'(1'b1));
            step();
        end
        drive(0, 0, '0, '0); steps(4);
        chk("b2b_rsp_count", DW'(n_rsp - r0), DW'(32));

        // Random mixed traffic in always-active mode.
        for (int k = 0; k < 300; k++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), rnd_data());
            step();
        end
        drive(0, 0, '0, '0); steps(20);
        chk("m00_no_ls", DW'({mem_ls, pwr_state}), '0);

        // Mode 01: the mode-change cycle clears the count, then 16 idle cycles enter light sleep.
        pwr_mode = 2'b01;
        for (int k = 0; k < 16; k++) begin
            step();
            chk("ls_wait", DW'(mem_ls), '0);
        end
        step();
        chk("ls_enter", DW'(mem_ls), DW'(1'b1));
        chk("ls_state", DW'(pwr_state), DW'(3'd1));
        chk("ls_ready", DW'(dp.req_ready), '0);
        steps(3);
        chk("ls_hold", DW'(pwr_state), DW'(3'd1));

        drive(1, 0, 5'd5, '0);
        step();
        chk("lswake_ls", DW'(mem_ls), '0);
        chk("lswake_state", DW'(pwr_state), DW'(3'd4));
        chk("lswake_ready", DW'(dp.req_ready), '0);
        step();
        chk("lswake_ready2", DW'(dp.req_ready), '0);
        step();
        chk("lswake_active", DW'(pwr_state), '0);
        chk("lswake_ready3", DW'(dp.req_ready), DW'(1'b1));
        step();
        drive(0, 0, '0, '0);

        // Read accepted above; 3 drain cycles then 15 idle counts -> count is 15 here.
        steps(18);
        chk("c15_state", DW'(pwr_state), '0);
        chk("c15_ready", DW'(dp.req_ready), DW'(1'b1));
        drive(1, 0, 5'($urandom_range(0, 31)), '0);
        step();
        drive(0, 0, '0, '0);
        for (int k = 0; k < 18; k++) begin
            step();
            chk("c15_no_ls", DW'(mem_ls), '0);
        end
        step();
        chk("c15_ls_again", DW'(mem_ls), DW'(1'b1));
        pwr_mode = 2'b00;
        steps(3);
        chk("ls_exit_active", DW'(pwr_state), '0);
        chk("ls_exit_ready", DW'(dp.req_ready), DW'(1'b1));

        // Deep sleep requested with three reads in flight.
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 5'(k + 7), '0);
            step();
        end
        drive(0, 0, '0, '0);
        pwr_mode = 2'b10;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("ds_drain", DW'(mem_ds), '0);
            chk("ds_ready", DW'(dp.req_ready), '0);
        end
        step();
        chk("ds_enter", DW'(mem_ds), DW'(1'b1));
        chk("ds_state", DW'(pwr_state), DW'(3'd2));
        chk("ds_all_rsp", DW'(rq.size()), '0);
        pwr_mode = 2'b00;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("dswake_state", DW'(pwr_state), DW'(3'd4));
            chk("dswake_ready", DW'(dp.req_ready), '0);
        end
        step();
        chk("dswake_active", DW'(pwr_state), '0);
        chk("dswake_ready1", DW'(dp.req_ready), DW'(1'b1));

        // Shutdown, then a deep-sleep command must pass through WAKE and ACTIVE first.
        pwr_mode = 2'b11;
        step();
        chk("sd_enter", DW'({mem_ls, mem_ds, mem_sd}), DW'(3'b001));
        chk("sd_state", DW'(pwr_state), DW'(3'd3));
        pwr_mode = 2'b10;
        step();
        chk("sd2ds_wake", DW'(pwr_state), DW'(3'd4));
        chk("sd2ds_pins", DW'({mem_ls, mem_ds, mem_sd}), '0);
        steps(8);
        chk("sd2ds_active", DW'(pwr_state), '0);
        chk("sd2ds_ready", DW'(dp.req_ready), '0);
        step();
        chk("sd2ds_ds", DW'(mem_ds), DW'(1'b1));
        pwr_mode = 2'b00;
        steps(9);
        chk("sd2ds_back", DW'(pwr_state), '0);

        // Reset one cycle after a read accept: the read must vanish.
        drive(1, 0, 5'd3, '0);
        step();
        drive(0, 0, '0, '0);
        rst = 1'b1;
        #1;
        check_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        cyc++;
        rq.delete();
        last_rd = 0;
        steps(6);
        chk("post_rst_state", DW'(pwr_state), '0);
        chk("post_rst_ready", DW'(dp.req_ready), DW'(1'b1));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
